// File: rtl/sar_search_pkg.sv
// Shared definitions for the successive-approximation search controller and
// the benches that drive it against a magnitude comparator.
package sar_search_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PROBE = 2'd1,
      DONE  = 2'd2
   } sar_state_t;

   // A well-formed comparator result has exactly one of gt/eq/lt set.
   function automatic logic cmp_onehot(input logic gt, input logic eq, input logic lt);
      return ({gt, eq, lt} == 3'b100) || ({gt, eq, lt} == 3'b010) || ({gt, eq, lt} == 3'b001);
   endfunction

endpackage

// File: rtl/sar_search.sv
// Successive-approximation search: drives trial values to an external
// magnitude comparator and converges on the hidden target MSB first.
module sar_search
   import sar_search_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int SETTLE = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             cmp_gt,
   input  logic             cmp_eq,
   input  logic             cmp_lt,
   output logic [WIDTH-1:0] guess,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] result
);

   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   sar_state_t       r_state,  w_state_nxt;
   logic [WIDTH-1:0] r_acc,    w_acc_nxt;
   logic [WIDTH-1:0] r_guess,  w_guess_nxt;
   logic [WIDTH-1:0] r_result, w_result_nxt;
   logic [BW-1:0]    r_bit,    w_bit_nxt;
   logic [3:0]       r_settle, w_settle_nxt;
   logic             r_err,    w_err_nxt;

   logic [WIDTH-1:0] w_mask;
   logic [WIDTH-1:0] w_acc_upd;

   assign w_mask    = WIDTH'(1) << r_bit;
   assign w_acc_upd = cmp_gt ? (r_acc | w_mask) : (r_acc & ~w_mask);

   // NOTE: every next-state signal takes its hold value first, so no path
   // through the case statement can leave one unassigned and infer a latch.
   always_comb begin
      w_state_nxt  = r_state;
      w_acc_nxt    = r_acc;
      w_guess_nxt  = r_guess;
      w_result_nxt = r_result;
      w_bit_nxt    = r_bit;
      w_settle_nxt = r_settle;
      w_err_nxt    = r_err;

      case (r_state)
         IDLE: begin
            if (start) begin
               w_acc_nxt    = '0;
               w_bit_nxt    = BW'(WIDTH - 1);
               w_guess_nxt  = WIDTH'(1) << (WIDTH - 1);
               w_settle_nxt = 4'(SETTLE);
               w_err_nxt    = 1'b0;
               w_state_nxt  = PROBE;
            end
         end

         PROBE: begin
            if (abort) begin
               w_state_nxt = IDLE;
            end else if (r_settle != 4'd0) begin
               w_settle_nxt = r_settle - 4'd1;
            end else if (!cmp_onehot(cmp_gt, cmp_eq, cmp_lt)) begin
               w_err_nxt    = 1'b1;
               w_result_nxt = r_acc & ~w_mask;
               w_state_nxt  = DONE;
            end else if (cmp_eq) begin
               w_result_nxt = r_guess;
               w_state_nxt  = DONE;
            end else if (r_bit == '0) begin
               w_acc_nxt    = w_acc_upd;
               w_result_nxt = w_acc_upd;
               w_state_nxt  = DONE;
            end else begin
               // The next trial bit is the current mask shifted one place down.
               w_acc_nxt    = w_acc_upd;
               w_bit_nxt    = r_bit - BW'(1);
               w_guess_nxt  = w_acc_upd | (w_mask >> 1);
               w_settle_nxt = 4'(SETTLE);
            end
         end

         DONE: begin
            w_state_nxt = IDLE;
         end

         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_acc    <= '0;
         r_guess  <= '0;
         r_result <= '0;
         r_bit    <= BW'(WIDTH - 1);
         r_settle <= 4'd0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_acc    <= w_acc_nxt;
         r_guess  <= w_guess_nxt;
         r_result <= w_result_nxt;
         r_bit    <= w_bit_nxt;
         r_settle <= w_settle_nxt;
         r_err    <= w_err_nxt;
      end
   end

   assign guess  = r_guess;
   assign result = r_result;
   assign err    = r_err;
   assign busy   = (r_state == PROBE);
   assign done   = (r_state == DONE);

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search: two instances (SETTLE=0 and SETTLE=2) each
// probing a behavioural comparator; guesses and results go through a scoreboard.
module tb_sar_search;
   import sar_search_pkg::*;

   typedef struct {
      logic [3:0] result;
      logic       err;
      int         lat;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start0 = 1'b0, start1 = 1'b0;
   logic       abort0 = 1'b0, abort1 = 1'b0;
   logic [3:0] target0 = '0, target1 = '0;
   logic       bad0 = 1'b0;
   logic       sel = 1'b0;

   logic       gt0, eq0, lt0, gt1, eq1, lt1;
   logic [3:0] guess0, guess1, result0, result1;
   logic       busy0, busy1, done0, done1, err0, err1;

   logic [3:0] w_guess, w_result;
   logic       w_busy, w_done, w_err;

   int         n_assert = 0;
   int         n_fail   = 0;
   logic [3:0] q_guess[$];
   exp_t       q_res[$];

   always #5 clk = ~clk;

   // Behavioural comparator: target on a, guess on b; bad0 forces an all-zero result.
   assign gt0 = bad0 ? 1'b0 : (target0 > guess0);
   assign eq0 = bad0 ? 1'b0 : (target0 == guess0);
   assign lt0 = bad0 ? 1'b0 : (target0 < guess0);
   assign gt1 = target1 > guess1;
   assign eq1 = target1 == guess1;
   assign lt1 = target1 < guess1;

   assign w_guess  = sel ? guess1  : guess0;
   assign w_result = sel ? result1 : result0;
   assign w_busy   = sel ? busy1   : busy0;
   assign w_done   = sel ? done1   : done0;
   assign w_err    = sel ? err1    : err0;

   sar_search #(.WIDTH(4), .SETTLE(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
      .cmp_gt(gt0), .cmp_eq(eq0), .cmp_lt(lt0),
      .guess(guess0), .busy(busy0), .done(done0), .err(err0), .result(result0)
   );

   sar_search #(.WIDTH(4), .SETTLE(2)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
      .cmp_gt(gt1), .cmp_eq(eq1), .cmp_lt(lt1),
      .guess(guess1), .busy(busy1), .done(done1), .err(err1), .result(result1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_start(input logic v);
      if (sel) start1 = v;
      else     start0 = v;
   endtask

   // Run one search on the selected instance; inject_at >= 0 pulses start mid-search.
   task automatic search(input logic [3:0] tgt, input logic [3:0] g0, input logic [3:0] g1,
                         input logic [3:0] g2, input logic [3:0] g3, input int n_probe,
                         input logic [3:0] exp_res, input logic exp_err, input int settle,
                         input int inject_at);
      logic [3:0] gl[4];
      exp_t       e;
      exp_t       got;
      int         cyc;
      bit         seen;
      gl[0] = g0; gl[1] = g1; gl[2] = g2; gl[3] = g3;
      if (sel) target1 = tgt;
      else     target0 = tgt;
      for (int p = 0; p < n_probe; p++)
         for (int s = 0; s <= settle; s++) q_guess.push_back(gl[p]);
      e.result = exp_res;
      e.err    = exp_err;
      e.lat    = n_probe * (1 + settle);
      q_res.push_back(e);

      drive_start(1'b1);
      step();
      drive_start(1'b0);
      check("err_cleared_on_start", w_err, 1'b0);
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 60) begin
         if (w_busy) begin
            if (q_guess.size() > 0) check("guess", w_guess, q_guess.pop_front());
            else                    check("extra_probe_cycle", w_busy, 1'b0);
         end
         drive_start(cyc == inject_at);
         step();
         cyc++;
         if (w_done) seen = 1'b1;
      end
      drive_start(1'b0);
      check("done_seen", seen, 1'b1);
      got = q_res.pop_front();
      check("done_latency", cyc, got.lat);
      check("result", w_result, got.result);
      check("err", w_err, got.err);
      check("busy_in_done", w_busy, 1'b0);
      check("guess_queue_drained", q_guess.size(), 0);
      q_guess.delete();
      step();
      check("done_one_cycle", w_done, 1'b0);
      check("result_held", w_result, got.result);
   endtask

   initial begin
      // Reset state.
      step();
      step();
      check("rst_guess", guess0, 4'd0);
      check("rst_result", result0, 4'd0);
      check("rst_busy", busy0, 1'b0);
      check("rst_done", done0, 1'b0);
      check("rst_err", err0, 1'b0);
      check("rst_busy1", busy1, 1'b0);
      rst_n = 1'b1;
      step();

      // SETTLE=0 searches.
      sel = 1'b0;
      search(4'd5,  4'd8, 4'd4,  4'd6,  4'd5,  4, 4'd5,  1'b0, 0, -1);
      search(4'd8,  4'd8, 4'd0,  4'd0,  4'd0,  1, 4'd8,  1'b0, 0, -1);
      search(4'd0,  4'd8, 4'd4,  4'd2,  4'd1,  4, 4'd0,  1'b0, 0, -1);
      search(4'd15, 4'd8, 4'd12, 4'd14, 4'd15, 4, 4'd15, 1'b0, 0, -1);

      // Non-one-hot compare on the first probe.
      bad0 = 1'b1;
      search(4'd9,  4'd8, 4'd0,  4'd0,  4'd0,  1, 4'd0,  1'b1, 0, -1);
      bad0 = 1'b0;
      search(4'd8,  4'd8, 4'd0,  4'd0,  4'd0,  1, 4'd8,  1'b0, 0, -1);

      // Abort at the second sample edge.
      target0 = 4'd5;
      start0 = 1'b1;
      step();
      start0 = 1'b0;
      step();
      check("abort_pre_busy", busy0, 1'b1);
      check("abort_pre_guess", guess0, 4'd4);
      abort0 = 1'b1;
      step();
      abort0 = 1'b0;
      check("abort_busy", busy0, 1'b0);
      check("abort_done", done0, 1'b0);
      check("abort_result", result0, 4'd8);
      step();
      check("abort_no_done_later", done0, 1'b0);
      check("abort_guess_held", guess0, 4'd4);

      // Abort outside PROBE is ignored; start still works afterwards.
      abort0 = 1'b1;
      step();
      abort0 = 1'b0;
      check("idle_abort_ignored", result0, 4'd8);

      // SETTLE=2 with a stray start mid-search.
      sel = 1'b1;
      search(4'd11, 4'd8, 4'd12, 4'd10, 4'd11, 4, 4'd11, 1'b0, 2, 5);

      // Reset in the middle of a search.
      sel = 1'b0;
      target0 = 4'd5;
      start0 = 1'b1;
      step();
      start0 = 1'b0;
      step();
      check("mid_busy", busy0, 1'b1);
      rst_n = 1'b0;
      step();
      check("mid_rst_guess", guess0, 4'd0);
      check("mid_rst_result", result0, 4'd0);
      check("mid_rst_busy", busy0, 1'b0);
      check("mid_rst_done", done0, 1'b0);
      check("mid_rst_err", err0, 1'b0);
      rst_n = 1'b1;
      step();
      check("post_rst_no_done", done0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
